// File: rtl/bpu_pkg.sv
// Shared branch-prediction definitions: control-type codes, RAS link offset,
// default-configuration checkpoint layout and the active-slot picker.
package bpu_pkg;

   typedef enum logic [1:0] {
      TYPE_NONE   = 2'b00,
      TYPE_BRANCH = 2'b01,
      TYPE_RET    = 2'b10,
      TYPE_CALL   = 2'b11
   } ctl_type_e;

   localparam int RAS_LINK_OFFSET = 8;
   localparam int RAS_DEPTH       = 8;
   localparam int RAS_AW          = 32;
   localparam int RAS_PTR_W       = $clog2(RAS_DEPTH);
   localparam int RAS_CNT_W       = $clog2(RAS_DEPTH + 1);

   typedef struct packed {
      logic [RAS_AW-1:0]    top_addr;
      logic [RAS_PTR_W-1:0] sp;
      logic [RAS_CNT_W-1:0] cnt;
   } ras_ckpt_t;

   typedef struct packed {
      logic      act;
      logic      slot;
      ctl_type_e typ;
   } slot_sel_t;

   // First RET/CALL in program order wins; branches do not end the scan.
   function automatic slot_sel_t pick_slot(input logic [1:0] t1, input logic [1:0] t2);
      slot_sel_t s;
      s.act  = 1'b0;
      s.slot = 1'b0;
      s.typ  = TYPE_NONE;
      if (t1 == TYPE_RET || t1 == TYPE_CALL) begin
         s.act = 1'b1;
         s.typ = ctl_type_e'(t1);
      end else if (t2 == TYPE_RET || t2 == TYPE_CALL) begin
         s.act  = 1'b1;
         s.slot = 1'b1;
         s.typ  = ctl_type_e'(t2);
      end
      return s;
   endfunction

endpackage

// File: rtl/ras_ckpt.sv
// Checkpointed return address stack: two-slot fetch prediction, speculative
// push/pop, and restore-plus-replay on EX redirect.
module ras_ckpt
   import bpu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 32,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int CKPT_W = AW + PTR_W + CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_valid_i,
   input  logic              fetch_stall_i,
   input  logic [AW-1:0]     fetch_pc_i,
   input  logic [1:0]        slot_type1_i,
   input  logic [1:0]        slot_type2_i,
   output logic              ras_valid_o,
   output logic              ras_slot_o,
   output logic [AW-1:0]     ras_target_o,
   output logic [CKPT_W-1:0] ckpt_o,
   input  logic              ex_redirect_i,
   input  logic [CKPT_W-1:0] ex_ckpt_i,
   input  logic [1:0]        ex_type_i,
   input  logic [AW-1:0]     ex_pc_i
);

   typedef struct packed {
      logic [AW-1:0]    top_addr;
      logic [PTR_W-1:0] sp;
      logic [CNT_W-1:0] cnt;
   } ckpt_t;

   logic [AW-1:0]    stack [DEPTH];
   logic [PTR_W-1:0] sp;
   logic [CNT_W-1:0] cnt;

   slot_sel_t        sel;
   ckpt_t            ex_ck;
   logic [AW-1:0]    top;
   logic [AW-1:0]    slot_pc;
   logic [AW-1:0]    fetch_link;
   logic [AW-1:0]    ex_link;
   logic [PTR_W-1:0] push_idx;
   logic [PTR_W-1:0] ex_push_idx;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] ex_cnt_inc;

   assign sel         = pick_slot(slot_type1_i, slot_type2_i);
   assign ex_ck       = ex_ckpt_i;
   assign top         = stack[sp];
   assign slot_pc     = sel.slot ? fetch_pc_i + AW'(4) : fetch_pc_i;
   assign fetch_link  = slot_pc + AW'(RAS_LINK_OFFSET);
   assign ex_link     = ex_pc_i + AW'(RAS_LINK_OFFSET);
   assign push_idx    = sp + PTR_W'(1);
   assign ex_push_idx = ex_ck.sp + PTR_W'(1);
   // Occupancy saturates; a push on a full stack silently drops the oldest entry.
   assign cnt_inc     = (cnt == CNT_W'(DEPTH)) ? cnt : cnt + CNT_W'(1);
   assign ex_cnt_inc  = (ex_ck.cnt == CNT_W'(DEPTH)) ? ex_ck.cnt : ex_ck.cnt + CNT_W'(1);

   always_comb begin
      ras_valid_o  = 1'b0;
      ras_slot_o   = 1'b0;
      ras_target_o = '0;
      ckpt_o       = '0;
      if (rst) begin
         ckpt_o     = {top, sp, cnt};
         ras_slot_o = sel.slot;
         if (sel.typ == TYPE_RET && fetch_valid_i && cnt != '0) begin
            ras_valid_o  = 1'b1;
            ras_target_o = top;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
         sp  <= '0;
         cnt <= '0;
      end else if (ex_redirect_i) begin
         // Top repair and replayed push hit different entries, so both land.
         stack[ex_ck.sp] <= ex_ck.top_addr;
         sp              <= ex_ck.sp;
         cnt             <= ex_ck.cnt;
         if (ex_type_i == TYPE_CALL) begin
            stack[ex_push_idx] <= ex_link;
            sp                 <= ex_push_idx;
            cnt                <= ex_cnt_inc;
         end else if (ex_type_i == TYPE_RET && ex_ck.cnt != '0) begin
            sp  <= ex_ck.sp - PTR_W'(1);
            cnt <= ex_ck.cnt - CNT_W'(1);
         end
      end else if (fetch_valid_i && !fetch_stall_i) begin
         if (sel.typ == TYPE_CALL) begin
            stack[push_idx] <= fetch_link;
            sp              <= push_idx;
            cnt             <= cnt_inc;
         end else if (sel.typ == TYPE_RET && cnt != '0) begin
            sp  <= sp - PTR_W'(1);
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule
